digit_score_ctrl: RTL and testbench
===================================

// Module: digit_score_ctrl
// PURPOSE
//  Sequencing controller for the on-screen two-digit score digit generators.
//  Holds a live BCD score, advances it on point events and publishes it to the
//  digit generators only at frame boundaries, so a digit never tears mid-frame.
//  Runs the game-phase state machine and selects the 6-bit RRGGBB digit colour.
//  Sits between game logic and the per-digit VGA pattern generators.
// PARAMETERS
//  WIN_SCORE     10  binary score (0..99) that moves PLAY -> WIN
//  BLINK_FRAMES  15  frame_start pulses per half-period of the WIN flash
// PORTS
//  clk           in   1  pixel clock; single clock domain
//  rst_n         in   1  asynchronous reset, active low
//  start         in   1  1-cycle pulse: begin a game (IDLE -> PLAY)
//  point         in   1  1-cycle pulse: score +1
//  clear         in   1  1-cycle pulse: zero score, return to IDLE
//  game_over     in   1  level: forces PLAY -> OVER
//  frame_start   in   1  1-cycle pulse at start of vertical blank
//  disp_tens     out  4  BCD tens digit for the digit generators
//  disp_ones     out  4  BCD ones digit for the digit generators
//  digit_colour  out  6  RRGGBB colour for lit digit segments
//  phase         out  2  00 IDLE, 01 PLAY, 10 WIN, 11 OVER
//  score_max     out  1  high while live score = 99
// BEHAVIOUR
//  - Reset (async, rst_n=0): phase IDLE, live and displayed score 00,
//    blink counter 0, blink phase on, digit_colour 111111, score_max 0.
//  - Live score: two BCD registers; ones 9 -> 0 carries into tens.
//    Nibbles never hold values above 9.
//  - point is accepted only in PLAY. Live score updates 1 cycle after the pulse.
//  - disp_* copy the live score on the cycle after frame_start, and only then.
//    A point at cycle t is shown after the first frame_start at or after t+1.
//  - Same cycle: clear beats point, start and game_over.
//    point plus frame_start: disp copies the pre-increment value.
//  - FSM, evaluated every cycle:
//    IDLE: start -> PLAY. point and game_over are ignored.
//    PLAY: game_over=1 -> OVER. If the live score after the increment is
//      >= WIN_SCORE (compared in binary, tens*10+ones) -> WIN in the same cycle.
//      game_over beats the win check.
//    WIN: points ignored; clear -> IDLE.
//    OVER: points ignored; clear -> IDLE.
//    In every state, clear -> IDLE and live score 00.
//    The clear also forces disp_* to 00 on the next cycle, without waiting
//    for frame_start.
//  - Colours: IDLE 111111; PLAY 001100; OVER 110000.
//    WIN alternates 111100 and 000000, starting at 111100.
//  - Blink: counts frame_start pulses in WIN only. At BLINK_FRAMES-1 it
//    wraps to 0 and toggles the blink phase. Entering WIN resets the counter
//    to 0 and the phase to on.
//  - digit_colour and phase are registered: they change 1 cycle after the
//    causing event.
//  - 99 + point: behaviour depends on the CONFIGURATION macro below.
// CONFIGURATION
//  SCORE_WRAP_EN defined: 99 + point -> 00, no flag beyond score_max.
//  SCORE_WRAP_EN undefined: score saturates at 99 and further points are
//    dropped. Default is undefined.
//  A point at 99 in PLAY only occurs when WIN_SCORE > 99, which disables WIN.
// TESTING
//  1. Reset, start, 3 points, no frame_start -> disp 00. One frame_start ->
//     disp 03 one cycle later; phase 01; colour 001100.
//  2. Live score 09, then point -> live 10 (tens=1, ones=0). With WIN_SCORE=10:
//     phase 10, colour 111100. After 15 frame_starts -> 000000; after 30 -> 111100.
//  3. point and clear in the same cycle while in PLAY at 05 -> phase 00,
//     live 00, disp 00 next cycle, no increment.
//  4. game_over=1 while a point would reach WIN_SCORE -> phase 11,
//    colour 110000, live score still incremented.
//  5. WIN_SCORE=200, drive 100 points. With SCORE_WRAP_EN: final 00.
//     Without it: 99, score_max=1.
//  6. Assert rst_n low mid-WIN, between clock edges -> outputs return to reset
//     values immediately; phase 00, colour 111111.

Source files
------------

// File: rtl/digit_score_ctrl.sv
// Score/phase sequencer for the two-digit score generators; frame-synchronous display copy.
// Optional SCORE_WRAP_EN: 99 + point wraps to 00 instead of saturating at 99.
module digit_score_ctrl #(
    parameter int unsigned WIN_SCORE    = 10,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       point,
    input  logic       clear,
    input  logic       game_over,
    input  logic       frame_start,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic [5:0] digit_colour,
    output logic [1:0] phase,
    output logic       score_max
);

    localparam int unsigned       CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [5:0] COL_IDLE = 6'b111111;
    localparam logic [5:0] COL_PLAY = 6'b001100;
    localparam logic [5:0] COL_WIN  = 6'b111100;
    localparam logic [5:0] COL_OVER = 6'b110000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        OVER = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       ones_q, ones_d, tens_q, tens_d;
    logic [3:0]       disp_ones_q, disp_ones_d, disp_tens_q, disp_tens_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [5:0]       colour_q, colour_d;

    logic [3:0]       inc_ones, inc_tens;
    logic [3:0]       play_ones, play_tens;
    logic [6:0]       play_bin;
    logic             win_hit;

    // BCD +1; at 99 either hold or wrap depending on build option.
    always_comb begin
        inc_ones = ones_q;
        inc_tens = tens_q;
        if (ones_q == 4'd9) begin
            if (tens_q == 4'd9) begin
`ifdef SCORE_WRAP_EN
                inc_ones = '0;
                inc_tens = '0;
`else
                inc_ones = ones_q;
                inc_tens = tens_q;
`endif
            end else begin
                inc_ones = '0;
                inc_tens = tens_q + 4'd1;
            end
        end else begin
            inc_ones = ones_q + 4'd1;
        end
    end

    // Win check uses the post-increment score, in binary.
    always_comb begin
        play_ones = point ? inc_ones : ones_q;
        play_tens = point ? inc_tens : tens_q;
        play_bin  = {play_tens, 3'b000} + {2'b00, play_tens, 1'b0} + {3'b000, play_ones};
        win_hit   = (32'(play_bin) >= WIN_SCORE);
    end

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        disp_ones_d = disp_ones_q;
        disp_tens_d = disp_tens_q;
        if (clear) begin
            state_d     = IDLE;
            ones_d      = '0;
            tens_d      = '0;
            disp_ones_d = '0;
            disp_tens_d = '0;
        end else begin
            if (frame_start) begin
                disp_ones_d = ones_q;
                disp_tens_d = tens_q;
            end
            case (state_q)
                IDLE: if (start) state_d = PLAY;
                PLAY: begin
                    ones_d = play_ones;
                    tens_d = play_tens;
                    if (game_over)    state_d = OVER;
                    else if (win_hit) state_d = WIN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (state_d == WIN && state_q != WIN) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (state_q == WIN && frame_start) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // Colour is derived from next-state so it lands on the same edge as phase.
    always_comb begin
        colour_d = COL_IDLE;
        case (state_d)
            IDLE:    colour_d = COL_IDLE;
            PLAY:    colour_d = COL_PLAY;
            WIN:     colour_d = blink_on_d ? COL_WIN : '0;
            OVER:    colour_d = COL_OVER;
            default: colour_d = COL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ones_q      <= '0;
            tens_q      <= '0;
            disp_ones_q <= '0;
            disp_tens_q <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            colour_q    <= COL_IDLE;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            disp_ones_q <= disp_ones_d;
            disp_tens_q <= disp_tens_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            colour_q    <= colour_d;
        end
    end

    assign disp_tens    = disp_tens_q;
    assign disp_ones    = disp_ones_q;
    assign digit_colour = colour_q;
    assign phase        = state_q;
    assign score_max    = (tens_q == 4'd9) && (ones_q == 4'd9);

endmodule

// File: tb/tb_digit_score_ctrl.sv
// Randomised + directed bench for digit_score_ctrl; two instances (WIN_SCORE 10 and 200)
// checked every cycle against an integer-level model of the score/phase rules.
module tb_digit_score_ctrl;

    localparam int BLINK = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, point = 1'b0, clear = 1'b0, game_over = 1'b0, frame_start = 1'b0;

    logic [3:0] disp_tens_w [2];
    logic [3:0] disp_ones_w [2];
    logic [5:0] colour_w    [2];
    logic [1:0] phase_w     [2];
    logic       smax_w      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_score_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .point(point), .clear(clear),
        .game_over(game_over), .frame_start(frame_start),
        .disp_tens(disp_tens_w[0]), .disp_ones(disp_ones_w[0]),
        .digit_colour(colour_w[0]), .phase(phase_w[0]), .score_max(smax_w[0])
    );

    digit_score_ctrl #(.WIN_SCORE(200), .BLINK_FRAMES(BLINK)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .point(point), .clear(clear),
        .game_over(game_over), .frame_start(frame_start),
        .disp_tens(disp_tens_w[1]), .disp_ones(disp_ones_w[1]),
        .digit_colour(colour_w[1]), .phase(phase_w[1]), .score_max(smax_w[1])
    );

    // Behavioural model: integer score 0..99, phase number, frame counter.
    int win_at [2] = '{10, 200};
    int m_score [2] = '{0, 0};
    int m_disp  [2] = '{0, 0};
    int m_phase [2] = '{0, 0};
    int m_bcnt  [2] = '{0, 0};
    bit m_bon   [2] = '{1'b1, 1'b1};
    int o_score, o_phase;

    function automatic int score_plus_one(int s);
`ifdef SCORE_WRAP_EN
        return (s + 1) % 100;
`else
        return (s >= 99) ? 99 : s + 1;
`endif
    endfunction

    function automatic int exp_colour(int ph, bit on);
        case (ph)
            0:       return 6'b111111;
            1:       return 6'b001100;
            2:       return on ? 6'b111100 : 6'b000000;
            default: return 6'b110000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_score[k] = 0; m_disp[k] = 0; m_phase[k] = 0; m_bcnt[k] = 0; m_bon[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                o_score = m_score[k];
                o_phase = m_phase[k];
                if (clear) begin
                    m_disp[k]  = 0;
                    m_score[k] = 0;
                    m_phase[k] = 0;
                end else begin
                    if (frame_start) m_disp[k] = o_score;
                    if (o_phase == 0 && start) m_phase[k] = 1;
                    if (o_phase == 1) begin
                        if (point) m_score[k] = score_plus_one(o_score);
                        if (game_over)                     m_phase[k] = 3;
                        else if (m_score[k] >= win_at[k])  m_phase[k] = 2;
                    end
                end
                if (m_phase[k] == 2 && o_phase != 2) begin
                    m_bcnt[k] = 0;
                    m_bon[k]  = 1'b1;
                end else if (m_phase[k] == 2 && frame_start) begin
                    m_bcnt[k] = m_bcnt[k] + 1;
                    if (m_bcnt[k] == BLINK) begin
                        m_bcnt[k] = 0;
                        m_bon[k]  = ~m_bon[k];
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("disp_tens[%0d]", k), 32'(disp_tens_w[k]), 32'(m_disp[k] / 10));
            check($sformatf("disp_ones[%0d]", k), 32'(disp_ones_w[k]), 32'(m_disp[k] % 10));
            check($sformatf("phase[%0d]", k),     32'(phase_w[k]),     32'(m_phase[k]));
            check($sformatf("colour[%0d]", k),    32'(colour_w[k]),    32'(exp_colour(m_phase[k], m_bon[k])));
            check($sformatf("score_max[%0d]", k), 32'(smax_w[k]),      32'(m_score[k] == 99));
        end
    end

    // Inputs set just after a falling edge, held for one full cycle.
    task automatic drive(input logic s, input logic p, input logic c, input logic g, input logic f);
        start = s; point = p; clear = c; game_over = g; frame_start = f;
        @(negedge clk);
        start = 1'b0; point = 1'b0; clear = 1'b0; game_over = 1'b0; frame_start = 1'b0;
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0);
    endtask

    function automatic logic [31:0] disp_of(input int k);
        return {24'b0, disp_tens_w[k], disp_ones_w[k]};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_phase",  32'(phase_w[0]),  32'h0);
        check("rst_colour", 32'(colour_w[0]), 32'h3F);
        check("rst_disp",   disp_of(0),       32'h00);
        check("rst_smax",   32'(smax_w[0]),   32'h0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // 1: points are invisible until a frame_start
        drive(1, 0, 0, 0, 0);
        points(3);
        drive(0, 0, 0, 0, 0);
        check("t1_disp_hold", disp_of(0), 32'h00);
        drive(0, 0, 0, 0, 1);
        check("t1_disp",   disp_of(0),            32'h03);
        check("t1_phase",  32'(phase_w[0]),       32'h1);
        check("t1_colour", 32'(colour_w[0]),      32'b001100);

        // 2: 09 -> 10 reaches WIN; blink after 15 and 30 frames
        points(6);
        drive(0, 1, 0, 0, 0);
        check("t2_phase",  32'(phase_w[0]),  32'h2);
        check("t2_colour", 32'(colour_w[0]), 32'b111100);
        repeat (15) drive(0, 0, 0, 0, 1);
        check("t2_blink_off", 32'(colour_w[0]), 32'b000000);
        repeat (15) drive(0, 0, 0, 0, 1);
        check("t2_blink_on", 32'(colour_w[0]), 32'b111100);

        // 3: clear beats point
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        points(5);
        drive(0, 0, 0, 0, 1);
        check("t3_disp_pre", disp_of(0), 32'h05);
        drive(0, 1, 1, 0, 0);
        check("t3_phase", 32'(phase_w[0]), 32'h0);
        check("t3_disp",  disp_of(0),      32'h00);
        drive(0, 0, 0, 0, 1);
        check("t3_live",  disp_of(0),      32'h00);

        // 4: game_over beats win, score still increments
        drive(1, 0, 0, 0, 0);
        points(9);
        drive(0, 1, 0, 1, 0);
        check("t4_phase",  32'(phase_w[0]),  32'h3);
        check("t4_colour", 32'(colour_w[0]), 32'b110000);
        drive(0, 0, 0, 0, 1);
        check("t4_disp",   disp_of(0),       32'h10);

        // 5: 100 points with WIN disabled
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        points(100);
        drive(0, 0, 0, 0, 1);
`ifdef SCORE_WRAP_EN
        check("t5_disp", disp_of(1),        32'h00);
        check("t5_smax", 32'(smax_w[1]),    32'h0);
`else
        check("t5_disp", disp_of(1),        32'h99);
        check("t5_smax", 32'(smax_w[1]),    32'h1);
`endif
        check("t5_phase", 32'(phase_w[1]),  32'h1);

        // 6: asynchronous reset mid-WIN
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        points(10);
        drive(0, 0, 0, 0, 1);
        check("t6_in_win", 32'(phase_w[0]), 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_phase",  32'(phase_w[0]),  32'h0);
        check("t6_colour", 32'(colour_w[0]), 32'h3F);
        check("t6_disp",   disp_of(0),       32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // randomised traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 7) == 0);
        end

        drive(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
